// File: rtl/pkt_frame_monitor_if.sv
// Word stream between pipeline stages of the user data path.
// The writer drives a word on data/ctrl and strobes wr; the reader drives rdy to grant
// space or accept data.
//   master: output data, ctrl, wr; input rdy
//   slave : input  data, ctrl, wr; output rdy
interface pkt_frame_monitor_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (output data, output ctrl, output wr, input rdy);
  modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/pkt_frame_monitor.sv
// Output stage after the ALU datapath. It absorbs the upstream write stream in a small FIFO,
// re-drives words downstream under out_if.rdy, and checks NetFPGA packet framing
// (module headers ctrl=all-ones, body ctrl=0, EOP ctrl one-hot).
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   in_if         upstream words (slave); rdy leaves one entry of margin for the write lag
//   out_if        downstream words (master); wr is a registered one-cycle valid
//   pkt_count_o   packets closed by a correct EOP (wraps)
//   word_count_o  words presented at the input, including dropped ones (wraps)
//   err_count_o   framing and overflow errors (saturates)
//   frame_err_o   one-cycle pulse per detected error
module pkt_frame_monitor #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                clk,
  input  logic                reset,
  pkt_frame_monitor_if.slave  in_if,
  pkt_frame_monitor_if.master out_if,
  output logic [31:0]         pkt_count_o,
  output logic [31:0]         word_count_o,
  output logic [15:0]         err_count_o,
  output logic                frame_err_o
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned WordW = CTRL_WIDTH + DATA_WIDTH;

  localparam logic [CntW-1:0]       DepthC   = CntW'(DEPTH);
  localparam logic [CntW-1:0]       DepthM1C = CntW'(DEPTH - 1);
  localparam logic [CTRL_WIDTH-1:0] CtrlHdr  = '1;

  typedef enum logic [1:0] {StIdle, StHdr, StBody} state_e;

  // FIFO storage and pointers
  logic [WordW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic push, pop, drop;

  // Output registers
  logic                  out_wr_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CTRL_WIDTH-1:0] out_ctrl_q;

  // Framing state and counters
  state_e      state_q, state_d;
  logic [31:0] pkt_count_q, word_count_q;
  logic [15:0] err_count_q;
  logic        frame_err_q;

  logic ctrl_hdr, ctrl_zero, ctrl_onehot;
  logic fsm_err, pkt_done, err_ev;

  // Push only below full; pop decision looks at count before this cycle's push, so a word
  // cannot bypass an empty FIFO.
  assign push = in_if.wr && (count_q < DepthC);
  assign drop = in_if.wr && (count_q == DepthC);
  assign pop  = out_if.rdy && (count_q != '0);

  // One spare entry absorbs the write that is already in flight when rdy falls.
  assign in_if.rdy = (count_q < DepthM1C);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_if.ctrl, in_if.data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_wr_q <= pop;
      if (pop) begin
        {out_ctrl_q, out_data_q} <= mem_q[rd_ptr_q];
      end
    end
  end

  assign out_if.wr   = out_wr_q;
  assign out_if.data = out_data_q;
  assign out_if.ctrl = out_ctrl_q;

  // Ctrl classification; all-ones takes precedence over one-hot.
  assign ctrl_hdr    = (in_if.ctrl == CtrlHdr);
  assign ctrl_zero   = (in_if.ctrl == '0);
  assign ctrl_onehot = !ctrl_zero &&
                       ((in_if.ctrl & (in_if.ctrl - CTRL_WIDTH'(1))) == '0);

  // Framing next state; only stored words advance it.
  always_comb begin
    state_d  = state_q;
    fsm_err  = 1'b0;
    pkt_done = 1'b0;
    if (push) begin
      case (state_q)
        StIdle: begin
          if (ctrl_hdr) state_d = StHdr;
          else          fsm_err = 1'b1;
        end
        StHdr: begin
          if (ctrl_hdr) begin
            state_d = StHdr;
          end else if (ctrl_zero) begin
            state_d = StBody;
          end else if (ctrl_onehot) begin
            state_d  = StIdle;
            pkt_done = 1'b1;
          end else begin
            state_d = StIdle;
            fsm_err = 1'b1;
          end
        end
        StBody: begin
          if (ctrl_hdr) begin
            // Truncated packet: the header opens the next one.
            state_d = StHdr;
            fsm_err = 1'b1;
          end else if (ctrl_zero) begin
            state_d = StBody;
          end else if (ctrl_onehot) begin
            state_d  = StIdle;
            pkt_done = 1'b1;
          end else begin
            state_d = StIdle;
            fsm_err = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Drop and framing error are mutually exclusive (drop means no push).
  assign err_ev = drop || fsm_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pkt_count_q  <= '0;
      word_count_q <= '0;
      err_count_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= err_ev;
      if (in_if.wr) word_count_q <= word_count_q + 32'd1;
      if (pkt_done) pkt_count_q  <= pkt_count_q + 32'd1;
      if (err_ev && (err_count_q != 16'hFFFF)) err_count_q <= err_count_q + 16'd1;
    end
  end

  assign pkt_count_o  = pkt_count_q;
  assign word_count_o = word_count_q;
  assign err_count_o  = err_count_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_pkt_frame_monitor.sv
module tb_pkt_frame_monitor;

  localparam int unsigned DW    = 64;
  localparam int unsigned CW    = 8;
  localparam int unsigned DEPTH = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pkt_count, word_count;
  logic [15:0] err_count;
  logic        frame_err;

  pkt_frame_monitor_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) in_bus ();
  pkt_frame_monitor_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) out_bus ();

  pkt_frame_monitor #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_if        (in_bus),
    .out_if       (out_bus),
    .pkt_count_o  (pkt_count),
    .word_count_o (word_count),
    .err_count_o  (err_count),
    .frame_err_o  (frame_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [CW+DW-1:0] mq[$];
  logic             m_out_wr  = 1'b0;
  logic [CW+DW-1:0] m_out_word = '0;
  logic [31:0]      m_pkt = '0, m_wc = '0;
  logic [15:0]      m_err = '0;
  logic             m_ferr = 1'b0;
  int               m_st = 0;  // 0: between packets, 1: after header(s), 2: in body

  function automatic void frame_step(input int st, input logic [CW-1:0] c,
                                     output int nst, output bit err, output bit done);
    bit hdr, body, eop;
    hdr  = (c == 8'hFF);
    body = (c == 8'h00);
    eop  = !hdr && ($countones(c) == 1);
    err  = 1'b0;
    done = 1'b0;
    nst  = st;
    if (st == 0) begin
      if (hdr) nst = 1;
      else     err = 1'b1;
    end else if (st == 1) begin
      if (hdr)       nst = 1;
      else if (body) nst = 2;
      else if (eop)  begin nst = 0; done = 1'b1; end
      else           begin nst = 0; err = 1'b1; end
    end else begin
      if (body)      nst = 2;
      else if (eop)  begin nst = 0; done = 1'b1; end
      else if (hdr)  begin nst = 1; err = 1'b1; end
      else           begin nst = 0; err = 1'b1; end
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_out_wr   = 1'b0;
      m_out_word = '0;
      m_pkt = '0; m_wc = '0; m_err = '0; m_ferr = 1'b0; m_st = 0;
    end else begin
      int  n, nst;
      bit  ferr, done;
      n = mq.size();
      if (out_bus.rdy && n != 0) begin
        m_out_word = mq.pop_front();
        m_out_wr   = 1'b1;
      end else begin
        m_out_wr = 1'b0;
      end
      m_ferr = 1'b0;
      if (in_bus.wr) begin
        m_wc = m_wc + 1;
        if (n >= DEPTH) begin
          m_ferr = 1'b1;
        end else begin
          mq.push_back({in_bus.ctrl, in_bus.data});
          frame_step(m_st, in_bus.ctrl, nst, ferr, done);
          m_st = nst;
          if (ferr) m_ferr = 1'b1;
          if (done) m_pkt = m_pkt + 1;
        end
        if (m_ferr && m_err != 16'hFFFF) m_err = m_err + 1;
      end
    end
  end

  // ---------------- cycle bookkeeping and compare ----------------
  int cyc = 0;
  int out_cnt = 0;
  int first_out_cyc = -1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      check("out_wr",     {63'd0, out_bus.wr},  {63'd0, m_out_wr});
      check("out_data",   out_bus.data,         m_out_word[DW-1:0]);
      check("out_ctrl",   {56'd0, out_bus.ctrl}, {56'd0, m_out_word[CW+DW-1:DW]});
      check("in_rdy",     {63'd0, in_bus.rdy},  {63'd0, (mq.size() < DEPTH - 1)});
      check("pkt_count",  {32'd0, pkt_count},   {32'd0, m_pkt});
      check("word_count", {32'd0, word_count},  {32'd0, m_wc});
      check("err_count",  {48'd0, err_count},   {48'd0, m_err});
      check("frame_err",  {63'd0, frame_err},   {63'd0, m_ferr});
      if (out_bus.wr) begin
        out_cnt++;
        if (out_cnt == 1) first_out_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_bus.ctrl = c;
    in_bus.data = d;
    in_bus.wr   = 1'b1;
    tick();
    in_bus.wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    #1 reset = 1'b0;
    tick();
    out_cnt       = 0;
    first_out_cyc = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int first_in_cyc;
    int written;
    logic [CW-1:0] pat [4];
    in_bus.wr   = 1'b0;
    in_bus.data = '0;
    in_bus.ctrl = '0;
    out_bus.rdy = 1'b0;

    // Test 1: single well-formed packet, latency and reset state
    do_reset();
    check("reset_out_wr", {63'd0, out_bus.wr}, 64'd0);
    check("reset_in_rdy", {63'd0, in_bus.rdy}, 64'd1);
    check("reset_pkt",    {32'd0, pkt_count},  64'd0);
    out_bus.rdy  = 1'b1;
    first_in_cyc = cyc;
    send(8'hFF, 64'h1111_0000_0000_0001);
    send(8'h00, 64'h2222_0000_0000_0002);
    send(8'h00, 64'h3333_0000_0000_0003);
    send(8'h01, 64'h4444_0000_0000_0004);
    repeat (6) tick();
    check("t1_out_pulses", out_cnt, 64'd4);
    check("t1_latency",    first_out_cyc - first_in_cyc, 64'd2);
    check("t1_pkt",        {32'd0, pkt_count},  64'd1);
    check("t1_words",      {32'd0, word_count}, 64'd4);
    check("t1_err",        {48'd0, err_count},  64'd0);

    // Test 2: back-pressure, in-flight write, overflow drop
    do_reset();
    out_bus.rdy = 1'b0;
    send(8'hFF, 64'hA0);
    send(8'h00, 64'hA1);
    send(8'h00, 64'hA2);
    check("t2_in_rdy_low", {63'd0, in_bus.rdy}, 64'd0);
    send(8'h00, 64'hA3);
    send(8'h01, 64'hA4);
    check("t2_drop_err",   {48'd0, err_count},  64'd1);
    check("t2_words",      {32'd0, word_count}, 64'd5);
    out_cnt     = 0;
    out_bus.rdy = 1'b1;
    repeat (8) tick();
    check("t2_out_pulses", out_cnt, 64'd4);

    // Test 3: leading body word is an error, then a header-only packet
    do_reset();
    out_bus.rdy = 1'b1;
    send(8'h00, 64'hB0);
    check("t3_err_first",  {48'd0, err_count}, 64'd1);
    check("t3_frame_err",  {63'd0, frame_err}, 64'd1);
    send(8'hFF, 64'hB1);
    send(8'h80, 64'hB2);
    check("t3_pkt",        {32'd0, pkt_count}, 64'd1);
    repeat (4) tick();

    // Test 4: truncated packet restarted by a new header
    do_reset();
    out_bus.rdy = 1'b1;
    send(8'hFF, 64'hC0);
    send(8'h00, 64'hC1);
    send(8'hFF, 64'hC2);
    check("t4_err_third", {48'd0, err_count}, 64'd1);
    send(8'h00, 64'hC3);
    send(8'h04, 64'hC4);
    repeat (6) tick();
    check("t4_pkt",        {32'd0, pkt_count}, 64'd1);
    check("t4_out_pulses", out_cnt, 64'd5);

    // Test 5: stream at full in_rdy rate with toggling out_rdy
    do_reset();
    pat[0] = 8'hFF; pat[1] = 8'h00; pat[2] = 8'h00; pat[3] = 8'h01;
    written = 0;
    for (int c = 0; c < 600 && written < 40; c++) begin
      out_bus.rdy = (c % 2 == 0);
      if (in_bus.rdy) begin
        in_bus.wr   = 1'b1;
        in_bus.ctrl = pat[written % 4];
        in_bus.data = 64'hD000 + 64'(written);
        written++;
      end else begin
        in_bus.wr = 1'b0;
      end
      tick();
    end
    in_bus.wr   = 1'b0;
    out_bus.rdy = 1'b1;
    repeat (8) tick();
    check("t5_written",    written, 64'd40);
    check("t5_out_pulses", out_cnt, 64'd40);
    check("t5_pkt",        {32'd0, pkt_count}, 64'd10);
    check("t5_err",        {48'd0, err_count}, 64'd0);

    // Test 6: asynchronous reset mid-packet with words queued
    do_reset();
    out_bus.rdy = 1'b0;
    send(8'hFF, 64'hE0);
    send(8'h00, 64'hE1);
    send(8'h00, 64'hE2);
    out_bus.rdy = 1'b1;
    tick();
    check("t6_out_wr_before", {63'd0, out_bus.wr}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_out_wr_rst",  {63'd0, out_bus.wr}, 64'd0);
    check("t6_in_rdy_rst",  {63'd0, in_bus.rdy}, 64'd1);
    check("t6_words_rst",   {32'd0, word_count}, 64'd0);
    check("t6_pkt_rst",     {32'd0, pkt_count},  64'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    tick();
    out_cnt = 0;
    send(8'hFF, 64'hF0);
    send(8'h02, 64'hF1);
    repeat (5) tick();
    check("t6_pkt",        {32'd0, pkt_count}, 64'd1);
    check("t6_err",        {48'd0, err_count}, 64'd0);
    check("t6_out_pulses", out_cnt, 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
